// File: rtl/sram_fetch_sequencer_if.sv
// Handshake and address bus between the string-match engine and the SRAM fetch sequencer.
// The master side issues fetch commands and stalls; the slave side drives the SRAM addresses.
interface sram_fetch_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr1;
    logic [ADDR_W-1:0] base_addr2;
    logic [CNT_W-1:0]  length;
    logic              stall;
    logic [ADDR_W-1:0] Address1;
    logic [ADDR_W-1:0] Address2;
    logic              word_valid;
    logic [CNT_W-1:0]  word_idx;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, base_addr1, base_addr2, length, stall,
        input  Address1, Address2, word_valid, word_idx, busy, done
    );

    modport slave (
        input  start, abort, base_addr1, base_addr2, length, stall,
        output Address1, Address2, word_valid, word_idx, busy, done
    );
endinterface

// File: rtl/sram_fetch_sequencer.sv
// Streams a run of consecutive word addresses to both SRAM read banks in lock-step,
// qualifying each returned word one cycle after its address was issued.
module sram_fetch_sequencer #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    sram_fetch_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, stateNext;
    logic [ADDR_W-1:0] addr1Q, addr1Next;
    logic [ADDR_W-1:0] addr2Q, addr2Next;
    logic [CNT_W-1:0]  remainingQ, remainingNext;
    logic [CNT_W-1:0]  issuedQ, issuedNext;
    logic [CNT_W-1:0]  idxQ, idxNext;
    logic              validQ, validNext;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr1Q     <= '0;
            addr2Q     <= '0;
            remainingQ <= '0;
            issuedQ    <= '0;
            idxQ       <= '0;
            validQ     <= 1'b0;
        end else begin
            state      <= stateNext;
            addr1Q     <= addr1Next;
            addr2Q     <= addr2Next;
            remainingQ <= remainingNext;
            issuedQ    <= issuedNext;
            idxQ       <= idxNext;
            validQ     <= validNext;
        end
    end

    always_comb begin
        stateNext     = state;
        addr1Next     = addr1Q;
        addr2Next     = addr2Q;
        remainingNext = remainingQ;
        issuedNext    = issuedQ;
        idxNext       = idxQ;
        validNext     = 1'b0;

        if (bus.abort) begin
            // Abort outranks start and stall; addresses are left where they were.
            stateNext = IDLE;
            idxNext   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr1Next     = bus.base_addr1;
                        addr2Next     = bus.base_addr2;
                        remainingNext = bus.length;
                        issuedNext    = '0;
                        stateNext     = (bus.length != '0) ? FETCH : DONE;
                    end
                end
                FETCH: begin
                    if (!bus.stall) begin
                        validNext     = 1'b1;
                        idxNext       = issuedQ;
                        issuedNext    = issuedQ + CNT_W'(1);
                        remainingNext = remainingQ - CNT_W'(1);
                        // The last address stays on the bus while its word is presented.
                        if (remainingQ == CNT_W'(1)) begin
                            stateNext = DRAIN;
                        end else begin
                            addr1Next = addr1Q + ADDR_W'(1);
                            addr2Next = addr2Q + ADDR_W'(1);
                        end
                    end
                end
                DRAIN:   stateNext = DONE;
                DONE:    stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    assign bus.Address1   = addr1Q;
    assign bus.Address2   = addr2Q;
    assign bus.word_valid = validQ;
    assign bus.word_idx   = idxQ;
    assign bus.busy       = (state == FETCH) || (state == DRAIN);
    assign bus.done       = (state == DONE);
endmodule

// File: doc/sram_fetch_sequencer.md
# sram_fetch_sequencer

Address sequencer that drives the two SRAM read ports (Address1 / Address2) feeding the string-match engine's 240-bit data inputs. On a start command it streams a programmable run of consecutive word addresses to both banks in lock-step. It honours a stall from the engine and flags, one cycle later, which SRAM output words are valid. It replaces the free-running address generator and gives the engine a defined frame: start, words, done.

## Interface
Parameters:
- ADDR_W, 8, SRAM address width; both banks use the same width.
- CNT_W, 8, width of length and word-index fields; must equal ADDR_W.

Ports (clock and reset first):
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately on assertion.
- start  in  1  begin a fetch run; sampled only in IDLE.
- abort  in  1  cancel the current run; takes effect in any state.
- base_addr1  in  ADDR_W  first word address, bank 1; sampled with start.
- base_addr2  in  ADDR_W  first word address, bank 2; sampled with start.
- length  in  CNT_W  number of words to fetch; sampled with start; 0 means no reads.
- stall  in  1  engine not ready; blocks issuing the current address.
- Address1  out  ADDR_W  registered SRAM bank-1 read address.
- Address2  out  ADDR_W  registered SRAM bank-2 read address.
- word_valid  out  1  SRAM outputs this cycle hold the word read at the previous edge.
- word_idx  out  CNT_W  index (0-based) of the word qualified by word_valid.
- busy  out  1  high in FETCH and DRAIN.
- done  out  1  one-cycle pulse at normal run completion.

## Operation
- States: IDLE, FETCH, DRAIN, DONE. A 2-bit encoding is acceptable.
- IDLE:
  - On start=1: load Address1←base_addr1, Address2←base_addr2, remaining←length, issued←0.
  - Next state is FETCH if length≠0, else DONE.
  - Without start, the addresses hold their last value.
- FETCH:
  - issue = !stall.
  - On issue: word_valid←1 next cycle, word_idx←issued, issued←issued+1, remaining←remaining−1.
  - If remaining==1 on issue: addresses hold and next state is DRAIN.
  - Otherwise both addresses increment by 1 modulo 2^ADDR_W (255→0 wrap, no carry out).
  - On !issue: addresses, counters and state hold, and word_valid←0 next cycle.
- DRAIN: lasts one cycle, exists to present the last word_valid; next state DONE.
- DONE: done=1 for exactly this cycle; next state IDLE.
- start is ignored outside IDLE.
- abort=1 in any state:
  - Next state is IDLE.
  - word_valid←0, and word_idx is cleared to 0.
  - done is not pulsed.
  - Addresses hold.
  - abort has priority over start and stall.
- Arithmetic: remaining and issued are CNT_W wide. A length of 255 completes with issued=255, so no overflow is possible.

## Timing
- Reset values: Address1=0, Address2=0, word_valid=0, word_idx=0, busy=0, done=0, state=IDLE.
- Start to first address: start sampled at edge N puts base on Address* after edge N, with busy=1 in cycle N+1.
- Word qualification: the address presented in cycle k with stall=0 yields word_valid=1 and the matching word_idx in cycle k+1. This matches the 1-cycle synchronous SRAM read.
- Run length: for length L with no stalls, busy lasts L+1 cycles (L FETCH, 1 DRAIN). done follows in the next cycle, and IDLE is re-entered one cycle after done.
- Each stalled FETCH cycle adds one cycle to the run.
- length=0: start leads to DONE in the next cycle, with done=1 and busy never asserted.
- Back-to-back runs: the earliest accepted next start is in the first IDLE cycle after done.
- Reset asserted mid-run: all outputs go to their reset values asynchronously. No done pulse is produced.

## Test plan
- Basic run: reset, then start with base1=0x10, base2=0x80, length=4, stall=0.
  - Address1 = 0x10,0x11,0x12,0x13 and Address2 = 0x80..0x83.
  - word_valid high for 4 cycles starting one cycle after the first address, with word_idx 0,1,2,3.
  - done pulses once, 6 cycles after the start edge.
- Wrap-around: base1=0xFE, base2=0xFF, length=3.
  - Address1 = 0xFE,0xFF,0x00 and Address2 = 0xFF,0x00,0x01.
  - word_idx 0..2, then done.
- Stall: length=3, stall high for 2 cycles in the second FETCH cycle.
  - The address holds during the stall.
  - word_valid shows the pattern 1,0,0,1,1.
  - done arrives 2 cycles later than in the unstalled run.
- Zero length and ignored start: start with length=0 produces done one cycle later, with busy=0 and word_valid=0 throughout. A start pulsed during a running length-5 job is ignored, and the addresses continue in sequence.
- Abort: abort asserted in the third FETCH cycle of a length-8 run.
  - Next cycle: state IDLE, word_valid=0, busy=0.
  - done stays 0, and Address* hold the base+2 value.
- Async reset: reset asserted between clock edges mid-run forces Address*=0, busy=0 and word_valid=0 before the next edge. After release, a fresh start runs normally.
